// File: rtl/ff_pkg.sv
// Mode encodings shared by the universal flip-flop register and its bit cells.
// No logic; constants only.
// No flow control.
package ff_pkg;

   localparam logic [1:0] MODE_D  = 2'b00;
   localparam logic [1:0] MODE_T  = 2'b01;
   localparam logic [1:0] MODE_JK = 2'b10;
   localparam logic [1:0] MODE_SR = 2'b11;

endpackage

// File: rtl/ff_cell.sv
// One bit of state acting as a D, T, JK or SR flip-flop chosen by mode.
// q and chg update on the sampling edge (1 cycle); illegal is combinational.
// No backpressure; en=0 holds q and clears chg.
module ff_cell
   import ff_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       a,
   input  logic       b,
   input  logic       rst_val,
   output logic       q,
   output logic       chg,
   output logic       illegal
);

   logic nxt;

   // Next-state mux; an SR S=R=1 request holds the bit and raises illegal.
   always_comb begin
      nxt     = q;
      illegal = 1'b0;
      case (mode)
         MODE_D:  nxt = a;
         MODE_T:  nxt = q ^ a;
         MODE_JK: begin
            case ({a, b})
               2'b01:   nxt = 1'b0;
               2'b10:   nxt = 1'b1;
               2'b11:   nxt = ~q;
               default: nxt = q;
            endcase
         end
         MODE_SR: begin
            case ({a, b})
               2'b01:   nxt = 1'b0;
               2'b10:   nxt = 1'b1;
               default: nxt = q;
            endcase
            illegal = en & a & b;
         end
         default: nxt = q;
      endcase
   end

   // State and change-detect flops; reset drops any in-flight update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= rst_val;
         chg <= 1'b0;
      end else if (en) begin
         q   <= nxt;
         chg <= nxt ^ q;
      end else begin
         chg <= 1'b0;
      end
   end

endmodule

// File: rtl/universal_ff_reg.sv
// WIDTH-bit register whose bits behave as D/T/JK/SR flops, with sticky SR-illegal flag.
// q, chg and err_flag update one edge after inputs are sampled; q_n is combinational from q.
// No backpressure; en=0 holds state and never sets err_flag.
module universal_ff_reg
   import ff_pkg::*;
#(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q_n,
   output logic [WIDTH-1:0] chg,
   output logic             err_flag
);

   logic [WIDTH-1:0] illegal;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      ff_cell u_cell (
         .clk     (clk),
         .rst_n   (rst_n),
         .en      (en),
         .mode    (mode),
         .a       (a[i]),
         .b       (b[i]),
         .rst_val (RESET_VAL[i]),
         .q       (q[i]),
         .chg     (chg[i]),
         .illegal (illegal[i])
      );
   end

   assign q_n = ~q;

   // Sticky error flag; a new illegal request outranks a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_flag <= 1'b0;
      end else if (|illegal) begin
         err_flag <= 1'b1;
      end else if (err_clr) begin
         err_flag <= 1'b0;
      end
   end

endmodule

// File: tb/tb_universal_ff_reg.sv
// Self-checking bench for universal_ff_reg: directed scenarios plus random traffic vs a model.
// Model state is advanced once per clock edge and compared 1 ns after the edge.
// No flow control in the DUT.
module tb_universal_ff_reg;

   localparam int         W  = 8;
   localparam logic [7:0] RV = 8'hA5;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         en = 1'b0;
   logic [1:0]   mode = 2'b00;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         err_clr = 1'b0;
   logic [W-1:0] q, q_n, chg;
   logic         err_flag;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference state
   logic [7:0] mq;
   logic [7:0] mchg;
   logic       merr;

   universal_ff_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .mode     (mode),
      .a        (a),
      .b        (b),
      .err_clr  (err_clr),
      .q        (q),
      .q_n      (q_n),
      .chg      (chg),
      .err_flag (err_flag)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Characteristic table of each flop type, one bit at a time.
   function automatic logic next_bit(input logic [1:0] m, input logic qi, input logic ai, input logic bi);
      logic [1:0] jk;
      jk = {ai, bi};
      case (m)
         2'd0: return ai;
         2'd1: return qi ^ ai;
         2'd2: return (jk == 2'b00) ? qi : (jk == 2'b01) ? 1'b0 : (jk == 2'b10) ? 1'b1 : ~qi;
         default: return (jk == 2'b01) ? 1'b0 : (jk == 2'b10) ? 1'b1 : qi;
      endcase
   endfunction

   task automatic check_all(input string tag);
      check_eq({tag, ".q"},   {24'd0, q},   {24'd0, mq});
      check_eq({tag, ".q_n"}, {24'd0, q_n}, {24'd0, ~mq});
      check_eq({tag, ".chg"}, {24'd0, chg}, {24'd0, mchg});
      check_eq({tag, ".err"}, {31'd0, err_flag}, {31'd0, merr});
   endtask

   // Apply one cycle of inputs, advance the model across the edge, then compare.
   task automatic cyc(input logic e, input logic [1:0] m, input logic [7:0] aa, input logic [7:0] bb,
                      input logic ec, input string tag);
      logic [7:0] nq;
      logic       ill;
      en = e; mode = m; a = aa; b = bb; err_clr = ec;
      nq  = mq;
      ill = 1'b0;
      if (e) begin
         for (int i = 0; i < 8; i++) nq[i] = next_bit(m, mq[i], aa[i], bb[i]);
         ill = (m == 2'd3) && ((aa & bb) != 8'd0);
      end
      @(posedge clk);
      #1;
      mchg = nq ^ mq;
      mq   = nq;
      if (ill)     merr = 1'b1;
      else if (ec) merr = 1'b0;
      check_all(tag);
   endtask

   task automatic model_reset();
      mq = RV; mchg = 8'd0; merr = 1'b0;
   endtask

   initial begin
      // 1: asynchronous reset, checked before any edge
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("rst_async");
      #5;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_all("rst_hold");

      // 2: D and T
      cyc(1, 2'd0, 8'h3C, 8'h00, 0, "d_3c");
      check_eq("d_3c.chg_lit", {24'd0, chg}, 32'h99);
      cyc(1, 2'd1, 8'hFF, 8'h00, 0, "t_ff");
      check_eq("t_ff.q_lit", {24'd0, q}, 32'hC3);
      cyc(1, 2'd1, 8'h00, 8'h00, 0, "t_00");

      // 3: JK
      cyc(1, 2'd0, 8'h0F, 8'h00, 0, "jk_pre");
      cyc(1, 2'd2, 8'hF0, 8'h0F, 0, "jk_set_rst");
      check_eq("jk_set_rst.q_lit", {24'd0, q}, 32'hF0);
      cyc(1, 2'd2, 8'hFF, 8'hFF, 0, "jk_tog");
      check_eq("jk_tog.q_lit", {24'd0, q}, 32'h0F);

      // 4: SR illegal, clear, set-wins
      cyc(1, 2'd0, 8'h00, 8'h00, 0, "sr_pre");
      cyc(1, 2'd3, 8'h03, 8'h01, 0, "sr_ill");
      check_eq("sr_ill.q_lit", {24'd0, q}, 32'h02);
      check_eq("sr_ill.err_lit", {31'd0, err_flag}, 32'd1);
      cyc(1, 2'd3, 8'h00, 8'h00, 1, "sr_clr");
      check_eq("sr_clr.err_lit", {31'd0, err_flag}, 32'd0);
      cyc(1, 2'd3, 8'h01, 8'h01, 1, "sr_setwins");
      check_eq("sr_setwins.err_lit", {31'd0, err_flag}, 32'd1);
      cyc(0, 2'd0, 8'h00, 8'h00, 1, "sr_clr2");

      // 5: enable low holds and never flags
      cyc(0, 2'd0, 8'hFF, 8'h00, 0, "hold_d");
      cyc(0, 2'd3, 8'hFF, 8'hFF, 0, "hold_sr");
      check_eq("hold_sr.err_lit", {31'd0, err_flag}, 32'd0);

      // 6: reset pulse while toggling
      cyc(1, 2'd1, 8'hFF, 8'h00, 0, "tog1");
      cyc(1, 2'd1, 8'hFF, 8'h00, 0, "tog2");
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_all("rst_midop");
      #2;
      rst_n = 1'b1;
      #1;
      check_eq("rst_midop.q_lit", {24'd0, q}, 32'hA5);
      cyc(1, 2'd1, 8'hFF, 8'h00, 0, "tog_after_rst");
      check_eq("tog_after_rst.q_lit", {24'd0, q}, 32'h5A);

      // Random traffic against the model
      for (int k = 0; k < 400; k++) begin
         cyc(($urandom_range(3) != 0), 2'($urandom_range(3)), 8'($urandom), 8'($urandom),
             ($urandom_range(4) == 0), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
